flash_cycle_ctrl: RTL and testbench

Parametrised successor to the U409 fixed-timing flash cycle machine. It turns a 68040-style bus start (TSn plus FLASH_SPACE decode) into flash chip-enable, read and write strobes with programmable wait, setup, pulse, hold and recovery counts, and returns a one-clock FLASH_TACK. An optional RDY/BSY gate holds off a new cycle while the device is busy programming or erasing. If the device stays busy too long, the cycle ends with a bus error.

---
 rtl/flash_cycle_pkg.sv | 20 ++
 rtl/flash_rdy_sync.sv | 29 ++
 rtl/flash_cycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_flash_cycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_cycle_pkg.sv
// Shared definitions for the flash cycle controller: the state encoding and the
// default width of the shared phase counter.
package flash_cycle_pkg;

    // RDYWAIT keeps its code in every build so the encoding never shifts when
    // the RDY gate is compiled in or out.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RDYWAIT  = 3'd1,
        ST_RD_ACC   = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5,
        ST_RECOVER  = 3'd6
    } flash_state_e;

    // Wide enough for the default RDY timeout of 1023 clocks.
    localparam int unsigned FLASH_CNT_W = 10;

endpackage

// File: rtl/flash_rdy_sync.sv
// Two-flop synchroniser for the asynchronous flash RDY/BSY# pin.
// Only compiled when FLASH_RDY_WAIT_EN is defined; the default build has no
// use for it. Resets to "busy" so a cycle cannot start on a stale ready level.
`ifdef FLASH_RDY_WAIT_EN
module flash_rdy_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rdy_i,
    output logic rdy_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only sync_q is used by the controller.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= rdy_i;
            sync_q <= meta_q;
        end
    end

    assign rdy_o = sync_q;

endmodule
`endif

// File: rtl/flash_cycle_ctrl.sv
// Flash cycle controller: turns a qualified bus start into flash ENn/READn/
// WRITEn strobes with programmable wait, setup, pulse, hold and recovery
// clocks, and returns a one-clock FLASH_TACK.
// Optional build macro FLASH_RDY_WAIT_EN: gate each new cycle on the flash
// RDY/BSY# pin and end with FLASH_TEA if the device stays busy too long.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | strobes high, waiting for TSn=0 with FLASH_SPACE=1
// ST_RDYWAIT  | device busy, ENn high, counting down the RDY timeout
// ST_RD_ACC   | ENn/READn low, counting READ_WAIT then one TACK clock
// ST_WR_SETUP | ENn low, WRITEn still high for WRITE_SETUP clocks
// ST_WR_PULSE | ENn/WRITEn low for WRITE_PULSE clocks, TACK in the last
// ST_WR_HOLD  | WRITEn high, ENn held low for WRITE_HOLD clocks
// ST_RECOVER  | all strobes high for RECOVERY clocks, new starts ignored
module flash_cycle_ctrl
    import flash_cycle_pkg::*;
#(
    parameter int unsigned READ_WAIT   = 2,
    parameter int unsigned WRITE_SETUP = 0,
    parameter int unsigned WRITE_PULSE = 2,
    parameter int unsigned WRITE_HOLD  = 1,
    parameter int unsigned RECOVERY    = 2,
    parameter int unsigned RDY_TIMEOUT = 1023,
    parameter int unsigned CNT_W       = FLASH_CNT_W
) (
    input  logic CLK40,
    input  logic RESETn,
    input  logic TSn,
    input  logic RnW,
    input  logic FLASH_SPACE,
    input  logic FLASH_RDY,
    output logic FLASH_TACK,
    output logic FLASH_TEA,
    output logic FLASH_ENn,
    output logic FLASH_READn,
    output logic FLASH_WRITEn,
    output logic FLASH_WPn,
    output logic FLASH_RSTn,
    output logic BUSY
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    // Where an access goes once ENn rises: straight to IDLE when no recovery
    // time is configured.
    localparam flash_state_e POST_ST   = (RECOVERY == 0) ? ST_IDLE : ST_RECOVER;
    localparam logic         POST_BUSY = (RECOVERY != 0);

    flash_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_n_q;
    logic             read_n_q;
    logic             write_n_q;
    logic             tack_q;
    logic             busy_q;

    logic accept;      // IDLE sees a decoded transfer start
    logic launch;      // strobes begin on this edge
    logic launch_rnw;  // direction of the access being launched

    assign accept = (state_q == ST_IDLE) && !TSn && FLASH_SPACE;

`ifdef FLASH_RDY_WAIT_EN
    logic rdy_s;
    logic rnw_q;
    logic tea_q;

    flash_rdy_sync u_rdy_sync (
        .clk_i  (CLK40),
        .rst_ni (RESETn),
        .rdy_i  (FLASH_RDY),
        .rdy_o  (rdy_s)
    );

    // A waiting cycle resumes exactly as if it had just been accepted, which
    // shifts every later timing by the number of RDYWAIT clocks.
    assign launch     = rdy_s && (accept || (state_q == ST_RDYWAIT));
    assign launch_rnw = (state_q == ST_RDYWAIT) ? rnw_q : RnW;
    assign FLASH_TEA  = tea_q;
`else
    logic unused_rdy;

    assign unused_rdy = FLASH_RDY;
    assign launch     = accept;
    assign launch_rnw = RnW;
    assign FLASH_TEA  = 1'b0;
`endif

    // Sequencer: every phase is timed by the single shared down-counter.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            en_n_q    <= 1'b1;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            tack_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FLASH_RDY_WAIT_EN
            rnw_q     <= 1'b1;
            tea_q     <= 1'b0;
`endif
        end else begin
            tack_q <= 1'b0;
`ifdef FLASH_RDY_WAIT_EN
            tea_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
`ifdef FLASH_RDY_WAIT_EN
                    if (accept) begin
                        rnw_q <= RnW;
                        if (!rdy_s) begin
                            state_q <= ST_RDYWAIT;
                            cnt_q   <= CNT_W'(RDY_TIMEOUT);
                            busy_q  <= 1'b1;
                        end
                    end
`endif
                end
`ifdef FLASH_RDY_WAIT_EN
                ST_RDYWAIT: begin
                    if (!rdy_s) begin
                        if (cnt_q <= CNT_ONE) begin
                            tea_q   <= 1'b1;
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
`endif
                ST_RD_ACC: begin
                    if (cnt_q == '0) begin
                        en_n_q   <= 1'b1;
                        read_n_q <= 1'b1;
                        state_q  <= POST_ST;
                        busy_q   <= POST_BUSY;
                        cnt_q    <= CNT_W'(RECOVERY);
                    end else begin
                        cnt_q  <= cnt_q - CNT_ONE;
                        tack_q <= (cnt_q == CNT_ONE);
                    end
                end
                ST_WR_SETUP: begin
                    if (cnt_q <= CNT_ONE) begin
                        write_n_q <= 1'b0;
                        state_q   <= ST_WR_PULSE;
                        cnt_q     <= CNT_W'(WRITE_PULSE);
                        tack_q    <= (WRITE_PULSE == 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_WR_PULSE: begin
                    if (cnt_q <= CNT_ONE) begin
                        write_n_q <= 1'b1;
                        if (WRITE_HOLD == 0) begin
                            en_n_q  <= 1'b1;
                            state_q <= POST_ST;
                            busy_q  <= POST_BUSY;
                            cnt_q   <= CNT_W'(RECOVERY);
                        end else begin
                            state_q <= ST_WR_HOLD;
                            cnt_q   <= CNT_W'(WRITE_HOLD);
                        end
                    end else begin
                        cnt_q  <= cnt_q - CNT_ONE;
                        tack_q <= (cnt_q == CNT_TWO);
                    end
                end
                ST_WR_HOLD: begin
                    if (cnt_q <= CNT_ONE) begin
                        en_n_q  <= 1'b1;
                        state_q <= POST_ST;
                        busy_q  <= POST_BUSY;
                        cnt_q   <= CNT_W'(RECOVERY);
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    en_n_q    <= 1'b1;
                    read_n_q  <= 1'b1;
                    write_n_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase

            // Start of the strobed part of an access; overrides the IDLE and
            // RDYWAIT handling above.
            if (launch) begin
                busy_q <= 1'b1;
                en_n_q <= 1'b0;
                if (launch_rnw) begin
                    state_q  <= ST_RD_ACC;
                    read_n_q <= 1'b0;
                    cnt_q    <= CNT_W'(READ_WAIT);
                end else if (WRITE_SETUP == 0) begin
                    state_q   <= ST_WR_PULSE;
                    write_n_q <= 1'b0;
                    cnt_q     <= CNT_W'(WRITE_PULSE);
                    tack_q    <= (WRITE_PULSE == 1);
                end else begin
                    state_q <= ST_WR_SETUP;
                    cnt_q   <= CNT_W'(WRITE_SETUP);
                end
            end
        end
    end

    assign FLASH_TACK   = tack_q;
    assign FLASH_ENn    = en_n_q;
    assign FLASH_READn  = read_n_q;
    assign FLASH_WRITEn = write_n_q;
    assign FLASH_WPn    = 1'b1;
    assign FLASH_RSTn   = RESETn;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_flash_cycle_ctrl.sv
// Testbench for flash_cycle_ctrl: a default-timing instance (A) and a
// short-timing instance (B: setup 2, pulse 1, hold 0, recovery 0) share the
// bus inputs. With FLASH_RDY_WAIT_EN, instance C (RDY timeout 8) is added.
`timescale 1ns/1ps
module tb_flash_cycle_ctrl;

    typedef struct packed {
        logic enn;
        logic readn;
        logic writen;
        logic tack;
        logic tea;
        logic busy;
    } outs_t;

    typedef struct {
        logic  tsn;
        logic  rnw;
        logic  space;
        outs_t exp;
    } vec_t;

    localparam outs_t IDLE_OUTS = 6'b111000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  = 1'b0;
    logic tsn    = 1'b1;
    logic rnw    = 1'b1;
    logic space  = 1'b0;
    logic rdy_ab = 1'b1;

    logic tack_a, tea_a, enn_a, readn_a, writen_a, wpn_a, rstn_a, busy_a;
    logic tack_b, tea_b, enn_b, readn_b, writen_b, wpn_b, rstn_b, busy_b;
    outs_t act_a, act_b;

    assign act_a = {enn_a, readn_a, writen_a, tack_a, tea_a, busy_a};
    assign act_b = {enn_b, readn_b, writen_b, tack_b, tea_b, busy_b};

    flash_cycle_ctrl u_dut_a (
        .CLK40(clk), .RESETn(rst_n), .TSn(tsn), .RnW(rnw),
        .FLASH_SPACE(space), .FLASH_RDY(rdy_ab),
        .FLASH_TACK(tack_a), .FLASH_TEA(tea_a), .FLASH_ENn(enn_a),
        .FLASH_READn(readn_a), .FLASH_WRITEn(writen_a), .FLASH_WPn(wpn_a),
        .FLASH_RSTn(rstn_a), .BUSY(busy_a)
    );

    flash_cycle_ctrl #(
        .READ_WAIT(2), .WRITE_SETUP(2), .WRITE_PULSE(1), .WRITE_HOLD(0),
        .RECOVERY(0)
    ) u_dut_b (
        .CLK40(clk), .RESETn(rst_n), .TSn(tsn), .RnW(rnw),
        .FLASH_SPACE(space), .FLASH_RDY(rdy_ab),
        .FLASH_TACK(tack_b), .FLASH_TEA(tea_b), .FLASH_ENn(enn_b),
        .FLASH_READn(readn_b), .FLASH_WRITEn(writen_b), .FLASH_WPn(wpn_b),
        .FLASH_RSTn(rstn_b), .BUSY(busy_b)
    );

`ifdef FLASH_RDY_WAIT_EN
    logic rdy_c = 1'b1;
    logic tack_c, tea_c, enn_c, readn_c, writen_c, wpn_c, rstn_c, busy_c;

    flash_cycle_ctrl #(.RDY_TIMEOUT(8)) u_dut_c (
        .CLK40(clk), .RESETn(rst_n), .TSn(tsn), .RnW(rnw),
        .FLASH_SPACE(space), .FLASH_RDY(rdy_c),
        .FLASH_TACK(tack_c), .FLASH_TEA(tea_c), .FLASH_ENn(enn_c),
        .FLASH_READn(readn_c), .FLASH_WRITEn(writen_c), .FLASH_WPn(wpn_c),
        .FLASH_RSTn(rstn_c), .BUSY(busy_c)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, edges elapsed since the accepting edge
    // (-1 when no cycle is in progress) and the direction of that cycle.
    int t_m[2]  = '{-1, -1};
    bit rd_m[2] = '{1'b0, 1'b0};

    // Expected outputs t edges after the accepting edge, from the cycle rules.
    function automatic outs_t model_out(int rw, int ws, int wp, int wh, int rec,
                                        int t, bit rd);
        outs_t o;
        int    wend;
        o    = IDLE_OUTS;
        wend = ws + wp;
        if (t < 0) return o;
        if (rd) begin
            o.enn   = !(t <= rw);
            o.readn = !(t <= rw);
            o.tack  = (t == rw);
            o.busy  = (t < rw + 1 + rec);
        end else begin
            o.enn    = !(t < wend + wh);
            o.writen = !(t >= ws && t < wend);
            o.tack   = (t == wend - 1);
            o.busy   = (t < wend + wh + rec);
        end
        return o;
    endfunction

    function automatic outs_t exp_for(int i);
        if (i == 0) return model_out(2, 0, 2, 1, 2, t_m[0], rd_m[0]);
        return model_out(2, 2, 1, 0, 0, t_m[1], rd_m[1]);
    endfunction

    task automatic chk1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(string name, outs_t act, outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b [enn readn writen tack tea busy] (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        outs_t e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            e = exp_for(i);
            if (!e.busy) begin
                if (rst_n && !tsn && space) begin
                    t_m[i]  = 0;
                    rd_m[i] = rnw;
                end else begin
                    t_m[i] = -1;
                end
            end else begin
                t_m[i] = t_m[i] + 1;
            end
        end
        @(negedge clk);
        chk_outs("model_a", act_a, exp_for(0));
        chk_outs("model_b", act_b, exp_for(1));
    endtask

    task automatic idle(int n);
        tsn = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic vec_t mkvec(logic ts, logic rw, logic sp, outs_t e);
        vec_t v;
        v.tsn   = ts;
        v.rnw   = rw;
        v.space = sp;
        v.exp   = e;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        // Instance A, default timing: read, write, ignored starts.
        tbl[0]  = mkvec(1'b0, 1'b1, 1'b1, 6'b001001); // read accepted
        tbl[1]  = mkvec(1'b1, 1'b1, 1'b1, 6'b001001);
        tbl[2]  = mkvec(1'b0, 1'b0, 1'b1, 6'b001101); // TACK; TS mid-cycle ignored
        tbl[3]  = mkvec(1'b1, 1'b1, 1'b1, 6'b111001); // strobes high, recover
        tbl[4]  = mkvec(1'b0, 1'b1, 1'b1, 6'b111001); // TS during recover ignored
        tbl[5]  = mkvec(1'b1, 1'b1, 1'b1, 6'b111000);
        tbl[6]  = mkvec(1'b0, 1'b0, 1'b1, 6'b010001); // write accepted
        tbl[7]  = mkvec(1'b1, 1'b0, 1'b1, 6'b010101); // TACK in last pulse clock
        tbl[8]  = mkvec(1'b0, 1'b1, 1'b1, 6'b011001); // WRITEn up, hold
        tbl[9]  = mkvec(1'b1, 1'b1, 1'b1, 6'b111001);
        tbl[10] = mkvec(1'b1, 1'b1, 1'b1, 6'b111001);
        tbl[11] = mkvec(1'b1, 1'b1, 1'b1, 6'b111000);
        tbl[12] = mkvec(1'b0, 1'b1, 1'b0, 6'b111000); // no decode hit
        tbl[13] = mkvec(1'b0, 1'b0, 1'b0, 6'b111000);
        tbl[14] = mkvec(1'b1, 1'b1, 1'b1, 6'b111000);

        // Reset state.
        #12;
        chk_outs("reset_a", act_a, IDLE_OUTS);
        chk_outs("reset_b", act_b, IDLE_OUTS);
        chk1("rstn_follow_low", rstn_a, 1'b0);
        chk1("wpn_tied", wpn_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rstn_follow_high", rstn_a, 1'b1);
        idle(3);

        for (int i = 0; i < 15; i++) begin
            tsn   = tbl[i].tsn;
            rnw   = tbl[i].rnw;
            space = tbl[i].space;
            tick();
            chk_outs($sformatf("table_%0d", i), act_a, tbl[i].exp);
        end
        idle(6);

        // Instance B: single-clock pulse, no hold, no recovery, back-to-back.
        tsn = 1'b0; rnw = 1'b0; space = 1'b1;
        tick();                               // edge 0
        tsn = 1'b1;
        tick();                               // edge 1
        chk1("b2b_wr_high_e1", writen_b, 1'b1);
        tick();                               // edge 2
        chk1("b2b_wr_low_e2", writen_b, 1'b0);
        chk1("b2b_tack_e2", tack_b, 1'b1);
        tick();                               // edge 3
        chk1("b2b_en_up_e3", enn_b, 1'b1);
        chk1("b2b_wr_up_e3", writen_b, 1'b1);
        chk1("b2b_tack_off_e3", tack_b, 1'b0);
        tsn = 1'b0; rnw = 1'b1;
        tick();                               // edge 4: accepted
        chk1("b2b_en_e4", enn_b, 1'b0);
        chk1("b2b_rd_e4", readn_b, 1'b0);
        idle(8);

        // Reset during A's write pulse.
        tsn = 1'b0; rnw = 1'b0; space = 1'b1;
        tick();                               // A now in WR_PULSE
        tsn = 1'b1;
        chk1("pre_rst_wr_low", writen_a, 1'b0);
        #2;
        rst_n = 1'b0;
        t_m[0] = -1;
        t_m[1] = -1;
        #1;
        chk1("rst_wr_high", writen_a, 1'b1);
        chk1("rst_en_high", enn_a, 1'b1);
        chk1("rst_no_tack", tack_a, 1'b0);
        chk1("rst_rstn_low", rstn_a, 1'b0);
        chk_outs("rst_b_idle", act_b, IDLE_OUTS);
        tick();
        rst_n = 1'b1;
        idle(3);
        tsn = 1'b0; rnw = 1'b1; space = 1'b1;
        tick();
        tsn = 1'b1;
        tick();
        tick();
        chk1("post_rst_read_tack", tack_a, 1'b1);
        idle(6);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tsn   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            rnw   = 1'($urandom_range(0, 1));
            space = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle(8);

`ifdef FLASH_RDY_WAIT_EN
        // C: RDY held low until the timeout.
        rdy_c = 1'b0;
        idle(3);
        tsn = 1'b0; rnw = 1'b1; space = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            tsn = 1'b1;
            chk1($sformatf("tmo_enn_%0d", k), enn_c, 1'b1);
            chk1($sformatf("tmo_tea_%0d", k), tea_c, (k == 8));
            chk1($sformatf("tmo_busy_%0d", k), busy_c, (k < 8));
        end
        idle(4);

        // C: RDY rises after edge 2, seen through the synchroniser at edge 5.
        tsn = 1'b0; rnw = 1'b1; space = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            tsn = 1'b1;
            if (k == 2) rdy_c = 1'b1;
            chk1($sformatf("rdy_enn_%0d", k), enn_c, !(k >= 5 && k <= 7));
            chk1($sformatf("rdy_tack_%0d", k), tack_c, (k == 7));
            chk1($sformatf("rdy_tea_%0d", k), tea_c, 1'b0);
        end
        idle(6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
